// File: rtl/rvfi_pc_chain_check.sv
// Purpose: checks PC continuity across DEPTH consecutive retire links after a triggered base order.
// Latency: mismatch is combinational; sticky errors, fail_link and links_done update 1 cycle later.
// Backpressure: none; a pure observer that accepts any number of retires per cycle on NRET channels.
module rvfi_pc_chain_check #(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int DEPTH     = 4,
  parameter int SKIP_INTR = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_trig,
  input  logic [63:0]          i_trig_order,
  input  logic                 i_check,
  input  logic [NRET-1:0]      i_rvfi_valid,
  input  logic [64*NRET-1:0]   i_rvfi_order,
  input  logic [XLEN*NRET-1:0] i_rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] i_rvfi_pc_wdata,
  input  logic [NRET-1:0]      i_rvfi_intr,
  output logic                 o_mismatch,
  output logic                 o_pc_error,
  output logic                 o_dup_error,
  output logic [4:0]           o_fail_link,
  output logic [4:0]           o_links_done,
  output logic                 o_all_done,
  output logic                 o_check_fail
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [63:0]      r_base;
  // Write side slot j holds retire B+j; read side slot j holds retire B+j+1.
  // Link k (1..DEPTH) therefore pairs write slot k-1 with read slot k-1.
  logic [XLEN-1:0]  r_wpc [DEPTH];
  logic [XLEN-1:0]  r_rpc [DEPTH];
  logic [DEPTH-1:0] r_wv, r_rv, r_ri, r_res;
  logic             r_pc_error, r_dup_error;
  logic [4:0]       r_fail_link, r_links_done;

  logic             w_active;
  logic [63:0]      w_base;
  logic [63:0]      w_off [NRET];
  logic [XLEN-1:0]  w_wpc_av [DEPTH];
  logic [XLEN-1:0]  w_rpc_av [DEPTH];
  logic [DEPTH-1:0] w_wv_av, w_rv_av, w_ri_av, w_res_eff;
  logic [DEPTH-1:0] w_link_res, w_link_fail;
  logic             w_dup, w_pc_err_eff;
  logic [4:0]       w_cnt, w_first_fail, w_done_eff, w_links_nxt, w_fail_nxt;
  logic [5:0]       w_sum;

  // Merge stored slots (cleared on a re-arm) with this cycle's retires, then resolve links.
  always_comb begin
    w_active     = (r_state != S_IDLE) || i_trig;
    w_base       = i_trig ? i_trig_order : r_base;
    w_wv_av      = i_trig ? '0 : r_wv;
    w_rv_av      = i_trig ? '0 : r_rv;
    w_ri_av      = i_trig ? '0 : r_ri;
    w_res_eff    = i_trig ? '0 : r_res;
    w_pc_err_eff = i_trig ? 1'b0 : r_pc_error;
    w_done_eff   = i_trig ? 5'd0 : r_links_done;
    w_wpc_av     = r_wpc;
    w_rpc_av     = r_rpc;
    w_dup        = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      w_off[c] = i_rvfi_order[64*c +: 64] - w_base;
    end
    // Lower channel index wins a same-cycle collision; a stored slot is never overwritten.
    for (int j = 0; j < DEPTH; j++) begin
      for (int c = 0; c < NRET; c++) begin
        if (w_active && i_rvfi_valid[c] && w_off[c] == 64'(j)) begin
          if (w_wv_av[j]) begin
            w_dup = 1'b1;
          end else begin
            w_wv_av[j]  = 1'b1;
            w_wpc_av[j] = i_rvfi_pc_wdata[XLEN*c +: XLEN];
          end
        end
        if (w_active && i_rvfi_valid[c] && w_off[c] == 64'(j + 1)) begin
          if (w_rv_av[j]) begin
            w_dup = 1'b1;
          end else begin
            w_rv_av[j]  = 1'b1;
            w_ri_av[j]  = i_rvfi_intr[c];
            w_rpc_av[j] = i_rvfi_pc_rdata[XLEN*c +: XLEN];
          end
        end
      end
    end
    w_cnt        = 5'd0;
    w_first_fail = 5'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_link_res[i]  = !w_res_eff[i] && w_wv_av[i] && w_rv_av[i];
      w_link_fail[i] = w_link_res[i] && !((SKIP_INTR != 0) && w_ri_av[i]) &&
                       (w_wpc_av[i] != w_rpc_av[i]);
      w_cnt = w_cnt + 5'(w_link_res[i]);
      if (w_link_fail[i]) w_first_fail = 5'(i + 1);
    end
    w_sum       = {1'b0, w_done_eff} + {1'b0, w_cnt};
    w_links_nxt = (w_sum > 6'(DEPTH)) ? 5'(DEPTH) : w_sum[4:0];
    w_fail_nxt  = i_trig ? 5'd0 : r_fail_link;
    if (!w_pc_err_eff && (|w_link_fail)) w_fail_nxt = w_first_fail;
  end

  // Next-state logic: arm from IDLE, re-arm on any trig, finish once every link resolved.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_trig) w_state_nxt = S_ARMED;
      S_ARMED: if (i_trig) w_state_nxt = S_ARMED;
               else if (r_links_done == 5'(DEPTH)) w_state_nxt = S_DONE;
      S_DONE:  if (i_trig) w_state_nxt = S_ARMED;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, scoreboard and sticky results; reset discards everything, including a same-cycle trig.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_wpc        <= '{default: '0};
      r_rpc        <= '{default: '0};
      r_wv         <= '0;
      r_rv         <= '0;
      r_ri         <= '0;
      r_res        <= '0;
      r_pc_error   <= 1'b0;
      r_dup_error  <= 1'b0;
      r_fail_link  <= 5'd0;
      r_links_done <= 5'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_base       <= w_base;
      r_wpc        <= w_wpc_av;
      r_rpc        <= w_rpc_av;
      r_wv         <= w_wv_av;
      r_rv         <= w_rv_av;
      r_ri         <= w_ri_av;
      r_res        <= w_res_eff | w_link_res;
      r_pc_error   <= w_pc_err_eff | (|w_link_fail);
      r_dup_error  <= (i_trig ? 1'b0 : r_dup_error) | w_dup;
      r_fail_link  <= w_fail_nxt;
      r_links_done <= w_links_nxt;
    end
  end

  assign o_mismatch   = |w_link_fail;
  assign o_pc_error   = r_pc_error;
  assign o_dup_error  = r_dup_error;
  assign o_fail_link  = r_fail_link;
  assign o_links_done = r_links_done;
  assign o_all_done   = (r_links_done == 5'(DEPTH));
  assign o_check_fail = i_check && (r_pc_error || o_mismatch || r_dup_error);

`ifdef FORMAL
  // The property this checker exists for: no broken PC chain and no duplicate retire.
  always_comb begin
    assert (!o_check_fail);
  end

  // The harness guarantees the base retire is visible on the trig cycle.
  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      if (i_trig && i_rvfi_order[64*c +: 64] == i_trig_order) assume (i_rvfi_valid[c]);
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
// Directed bench for rvfi_pc_chain_check with two retire channels and four links.
// Inputs change 1 ns after the rising edge; combinational outputs are sampled 1 ns later.
// Registered outputs are sampled 1 ns after the edge that captured them.
module tb_rvfi_pc_chain_check;

  logic         clk = 1'b0;
  logic         rst, trig, check;
  logic [63:0]  trig_order;
  logic [1:0]   valid, intr;
  logic [127:0] order;
  logic [63:0]  rdata, wdata;
  logic         mismatch, pc_error, dup_error, all_done, check_fail;
  logic [4:0]   fail_link, links_done;

  int tests = 0;
  int fails = 0;

  rvfi_pc_chain_check #(.XLEN(32), .NRET(2), .DEPTH(4), .SKIP_INTR(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_trig(trig), .i_trig_order(trig_order), .i_check(check),
    .i_rvfi_valid(valid), .i_rvfi_order(order), .i_rvfi_pc_rdata(rdata),
    .i_rvfi_pc_wdata(wdata), .i_rvfi_intr(intr),
    .o_mismatch(mismatch), .o_pc_error(pc_error), .o_dup_error(dup_error),
    .o_fail_link(fail_link), .o_links_done(links_done), .o_all_done(all_done),
    .o_check_fail(check_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trig  = 1'b0;
    valid = 2'b00;
    intr  = 2'b00;
  endtask

  task automatic ret(input int ch, input logic [63:0] ord, input logic [31:0] r,
                     input logic [31:0] w, input logic in);
    valid[ch]         = 1'b1;
    intr[ch]          = in;
    order[64*ch +: 64] = ord;
    rdata[32*ch +: 32] = r;
    wdata[32*ch +: 32] = w;
  endtask

  task automatic arm(input logic [63:0] b);
    trig       = 1'b1;
    trig_order = b;
  endtask

  initial begin
    rst = 1'b1; check = 1'b0; trig_order = '0; order = '0; rdata = '0; wdata = '0;
    clr();
    tick(); tick();
    chk("rst_mismatch", mismatch, 0);
    chk("rst_pc_error", pc_error, 0);
    chk("rst_dup_error", dup_error, 0);
    chk("rst_fail_link", fail_link, 0);
    chk("rst_links_done", links_done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_check_fail", check_fail, 0);
    rst = 1'b0;

    // Clean chain 10..14.
    arm(10); ret(0, 10, 32'h100, 32'h104, 0); tick(); clr();
    chk("t1_after_trig_done", links_done, 0);
    ret(0, 11, 32'h104, 32'h108, 0); #1;
    chk("t1_l1_mismatch", mismatch, 0);
    tick(); clr(); chk("t1_done1", links_done, 1);
    ret(0, 12, 32'h108, 32'h10c, 0); tick(); clr(); chk("t1_done2", links_done, 2);
    ret(0, 13, 32'h10c, 32'h110, 0); tick(); clr(); chk("t1_done3", links_done, 3);
    chk("t1_all_done_early", all_done, 0);
    ret(0, 14, 32'h110, 32'h114, 0); tick(); clr();
    chk("t1_done4", links_done, 4);
    chk("t1_all_done", all_done, 1);
    chk("t1_pc_error", pc_error, 0);

    // Broken link 2: order 12 reads 0x200 instead of 0x108.
    arm(10); ret(0, 10, 32'h100, 32'h104, 0); tick(); clr();
    chk("t2_rearm_all_done", all_done, 0);
    ret(0, 11, 32'h104, 32'h108, 0); tick(); clr();
    ret(0, 12, 32'h200, 32'h10c, 0); check = 1'b1; #1;
    chk("t2_mismatch_pulse", mismatch, 1);
    chk("t2_check_fail_comb", check_fail, 1);
    chk("t2_pc_error_not_yet", pc_error, 0);
    tick(); clr();
    chk("t2_mismatch_gone", mismatch, 0);
    chk("t2_pc_error", pc_error, 1);
    chk("t2_fail_link", fail_link, 2);
    chk("t2_check_fail", check_fail, 1);
    chk("t2_links_done", links_done, 2);
    check = 1'b0;

    // Two channels, same cycle as the re-arm: link 1 resolves immediately.
    arm(10); ret(0, 10, 32'h100, 32'h104, 0); ret(1, 11, 32'h104, 32'h108, 0); #1;
    chk("t3_mismatch", mismatch, 0);
    tick(); clr();
    chk("t3_links_done", links_done, 1);
    chk("t3_pc_error_cleared", pc_error, 0);
    chk("t3_fail_link_cleared", fail_link, 0);
    chk("t3_dup_error", dup_error, 0);

    // Order 13 enters a trap handler with a bogus rdata: link 3 skipped.
    ret(1, 12, 32'h108, 32'h10c, 0); ret(0, 13, 32'hDEAD, 32'h110, 1); #1;
    chk("t4_skip_no_mismatch", mismatch, 0);
    tick(); clr();
    chk("t4_links_done3", links_done, 3);
    ret(0, 14, 32'h110, 32'h114, 0); tick(); clr();
    chk("t4_links_done4", links_done, 4);
    chk("t4_all_done", all_done, 1);
    chk("t4_pc_error", pc_error, 0);

    // Out-of-order retire: 12 before 11.
    arm(10); tick(); clr();
    ret(0, 12, 32'h108, 32'h10c, 0); tick(); clr();
    chk("t5_ooo_none", links_done, 0);
    ret(0, 11, 32'h104, 32'h108, 0); tick(); clr();
    chk("t5_ooo_link2", links_done, 1);
    chk("t5_ooo_pc_error", pc_error, 0);

    // Order wrap-around: B = 2^64-2, chain continues through 0..2.
    arm(64'hFFFF_FFFF_FFFF_FFFE); ret(0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h1000, 32'h1004, 0);
    tick(); clr();
    chk("t5_wrap_cleared", links_done, 0);
    ret(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1004, 32'h1008, 0); ret(1, 0, 32'h1008, 32'h100c, 0);
    tick(); clr();
    chk("t5_wrap_done2", links_done, 2);
    ret(0, 1, 32'h100c, 32'h1010, 0); ret(1, 2, 32'h1010, 32'h1014, 0); #1;
    chk("t5_wrap_mismatch", mismatch, 0);
    tick(); clr();
    chk("t5_wrap_done4", links_done, 4);
    chk("t5_wrap_all_done", all_done, 1);
    chk("t5_wrap_pc_error", pc_error, 0);
    chk("t5_wrap_dup_error", dup_error, 0);

    // Duplicate retire of order 11, then reset mid-run.
    arm(10); ret(0, 10, 32'h100, 32'h104, 0); tick(); clr();
    ret(0, 11, 32'h104, 32'h108, 0); tick(); clr();
    chk("t6_dup_before", dup_error, 0);
    ret(0, 11, 32'h104, 32'h108, 0); tick(); clr();
    chk("t6_dup_error", dup_error, 1);
    chk("t6_no_double_count", links_done, 1);
    check = 1'b1; #1;
    chk("t6_check_fail_dup", check_fail, 1);
    rst = 1'b1; arm(10); ret(0, 12, 32'h108, 32'h10c, 0); tick(); clr();
    chk("t6_rst_dup_error", dup_error, 0);
    chk("t6_rst_links_done", links_done, 0);
    chk("t6_rst_pc_error", pc_error, 0);
    chk("t6_rst_all_done", all_done, 0);
    chk("t6_rst_check_fail", check_fail, 0);
    rst = 1'b0;
    ret(0, 10, 32'h100, 32'h104, 0); ret(1, 11, 32'h999, 32'h108, 0); #1;
    chk("t6_idle_ignored_mismatch", mismatch, 0);
    tick(); clr();
    chk("t6_idle_links_done", links_done, 0);
    chk("t6_idle_pc_error", pc_error, 0);
    chk("t6_idle_fail_link", fail_link, 0);
    check = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
